// File: rtl/lsu_pkg.sv
// Shared execute-stage enums and helpers: ALU opcodes, memory access sizes,
// and the load/store unit's transaction states.
package lsu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_t;

  typedef enum logic [1:0] {
    MEM_SIZE_BYTE = 2'd0,
    MEM_SIZE_HALF = 2'd1,
    MEM_SIZE_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT,
    LSU_RESP
  } lsu_state_t;

  // Encoding 3 is illegal and is reported as misaligned so it never reaches the bus.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      MEM_SIZE_BYTE: return 1'b0;
      MEM_SIZE_HALF: return off[0];
      MEM_SIZE_WORD: return off != 2'b00;
      default:       return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store enables/replication and misalignment
// on the request side, load extraction and sign/zero extension on the return side.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata_rep,
  output logic        st_misaligned,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shifted;
  logic        ld_sext;

  always_comb begin
    st_misaligned = is_misaligned(st_size, st_off);
    st_be         = 4'b1111;
    st_wdata_rep  = st_wdata;
    case (st_size)
      MEM_SIZE_BYTE: begin
        st_be        = 4'b0001 << st_off;
        st_wdata_rep = {4{st_wdata[7:0]}};
      end
      MEM_SIZE_HALF: begin
        st_be        = 4'b0011 << st_off;
        st_wdata_rep = {2{st_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Shift the addressed lane down to bit 0, then extend from its top bit.
  always_comb begin
    ld_shifted = ld_rdata >> {ld_off, 3'b000};
    ld_sext    = 1'b0;
    ld_data    = ld_rdata;
    case (ld_size)
      MEM_SIZE_BYTE: begin
        ld_sext = ~ld_unsigned & ld_shifted[7];
        ld_data = {{24{ld_sext}}, ld_shifted[7:0]};
      end
      MEM_SIZE_HALF: begin
        ld_sext = ~ld_unsigned & ld_shifted[15];
        ld_data = {{16{ld_sext}}, ld_shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: takes the ALU effective address, runs one req/gnt/rvalid
// bus transaction and returns an aligned, extended load result to writeback.
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mis_q, mis_d;
  logic        err_q, err_d;

  logic [3:0]  st_be;
  logic [31:0] st_wdata_rep;
  logic        st_mis;
  logic [31:0] ld_data;
  logic        accept;
  logic        tmo_hit;

  lsu_align u_align (
    .st_size      (req_size),
    .st_off       (addr[1:0]),
    .st_wdata     (wdata),
    .st_be        (st_be),
    .st_wdata_rep (st_wdata_rep),
    .st_misaligned(st_mis),
    .ld_size      (size_q),
    .ld_off       (off_q),
    .ld_unsigned  (uns_q),
    .ld_rdata     (mem_rdata),
    .ld_data      (ld_data)
  );

  assign accept  = req_valid && (state_q == LSU_IDLE);
  // Fires on the last allowed cycle in REQ/WAIT, so mem_req is up for exactly TIMEOUT_CYCLES.
  assign tmo_hit = (TIMEOUT_CYCLES > 0) && (cnt_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LSU_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      off_q   <= 2'b00;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      cnt_q   <= 32'd0;
      rdata_q <= 32'd0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: if (req_valid) state_d = st_mis ? LSU_RESP : LSU_REQ;
      LSU_REQ: begin
        if (mem_gnt)      state_d = LSU_WAIT;
        else if (tmo_hit) state_d = LSU_RESP;
      end
      LSU_WAIT: begin
        if (mem_rvalid)   state_d = LSU_RESP;
        else if (tmo_hit) state_d = LSU_RESP;
      end
      LSU_RESP: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_comb begin
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    if (accept) begin
      we_d    = req_we;
      size_d  = req_size;
      uns_d   = req_unsigned;
      off_d   = addr[1:0];
      addr_d  = {addr[31:2], 2'b00};
      be_d    = st_be;
      wdata_d = st_wdata_rep;
      rdata_d = 32'd0;
      mis_d   = st_mis;
      err_d   = 1'b0;
    end

    if (state_q == LSU_WAIT && mem_rvalid) begin
      rdata_d = we_q ? 32'd0 : ld_data;
    end else if ((state_q == LSU_REQ && !mem_gnt && tmo_hit) ||
                 (state_q == LSU_WAIT && tmo_hit)) begin
      rdata_d = 32'd0;
      err_d   = 1'b1;
    end

    // Restart on every state change; count only while a bus phase is pending.
    if (state_d != state_q)
      cnt_d = 32'd0;
    else if (TIMEOUT_CYCLES > 0 && (state_q == LSU_REQ || state_q == LSU_WAIT))
      cnt_d = cnt_q + 32'd1;
  end

  always_comb begin
    req_ready       = (state_q == LSU_IDLE);
    mem_req         = (state_q == LSU_REQ);
    resp_valid      = (state_q == LSU_RESP);
    mem_we          = we_q;
    mem_addr        = addr_q;
    mem_be          = be_q;
    mem_wdata       = wdata_q;
    resp_rdata      = rdata_q;
    resp_misaligned = mis_q;
    resp_err        = err_q;
  end

endmodule
